// File: rtl/simon_enc_ctrl_pkg.sv
// Shared Simon 32/64 constants, state encoding and the Z0 sequence lookup.
// Imported by the key schedule, the round cell and the controller.
package simon_pkg;

  localparam int SIMON_WORD = 16;
  localparam logic [SIMON_WORD-1:0] SIMON_C = 16'hFFFC;

  // Index 0 is the leftmost character, so bit i lives at Z0[61-i].
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CAPT,
    DONE
  } state_t;

  function automatic logic z0_bit(input logic [5:0] idx);
    return Z0[6'd61 - idx];
  endfunction

endpackage

// File: rtl/simon_enc_ctrl_if.sv
// Host-side handshake bundle for the Simon encryption controller.
// Master is the host; slave is the controller.
interface simon_enc_ctrl_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] pt;
  logic [63:0] key;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ct;
  logic        busy;

  modport master (
    output in_valid, pt, key, out_ready,
    input  in_ready, out_valid, ct, busy
  );

  modport slave (
    input  in_valid, pt, key, out_ready,
    output in_ready, out_valid, ct, busy
  );

endinterface

// File: rtl/round.sv
// Registered Simon 32 round cell: x' = y ^ f(x) ^ k, y' = x.
// Clocks every cycle with no enable; the controller decides when outputs matter.
module round
  import simon_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SIMON_WORD-1:0] u_in,
  input  logic [SIMON_WORD-1:0] l_in,
  input  logic [SIMON_WORD-1:0] subkey,
  output logic [SIMON_WORD-1:0] u_cphrtxt,
  output logic [SIMON_WORD-1:0] l_cphrtxt
);

  logic [SIMON_WORD-1:0] u_q, l_q, u_d, l_d, f;

  always_comb begin
    f   = ({u_in[14:0], u_in[15]} & {u_in[7:0], u_in[15:8]}) ^ {u_in[13:0], u_in[15:14]};
    u_d = l_in ^ f ^ subkey;
    l_d = u_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      u_q <= '0;
      l_q <= '0;
    end else begin
      u_q <= u_d;
      l_q <= l_d;
    end
  end

  assign u_cphrtxt = u_q;
  assign l_cphrtxt = l_q;

endmodule

// File: rtl/simon_key_sched.sv
// On-the-fly Simon 32/64 key expansion: four-word shift register whose
// head is the current round subkey.
module simon_key_sched
  import simon_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [63:0]           key,
  input  logic [CNT_W-1:0]      idx,
  output logic [SIMON_WORD-1:0] subkey
);

  logic [SIMON_WORD-1:0] kr0_q, kr1_q, kr2_q, kr3_q;
  logic [SIMON_WORD-1:0] kr0_d, kr1_d, kr2_d, kr3_d;
  logic [SIMON_WORD-1:0] tmp, tmp2, knew;

  always_comb begin
    tmp  = {kr3_q[2:0], kr3_q[15:3]} ^ kr1_q;
    tmp2 = tmp ^ {tmp[0], tmp[15:1]};
    knew = SIMON_C ^ kr0_q ^ tmp2 ^ {15'b0, z0_bit(6'(idx))};
  end

  // A load always wins over a step so a fresh key is never shifted on arrival.
  always_comb begin
    kr0_d = kr0_q;
    kr1_d = kr1_q;
    kr2_d = kr2_q;
    kr3_d = kr3_q;
    if (load) begin
      kr0_d = key[15:0];
      kr1_d = key[31:16];
      kr2_d = key[47:32];
      kr3_d = key[63:48];
    end else if (step) begin
      kr0_d = kr1_q;
      kr1_d = kr2_q;
      kr2_d = kr3_q;
      kr3_d = knew;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kr0_q <= '0;
      kr1_q <= '0;
      kr2_q <= '0;
      kr3_q <= '0;
    end else begin
      kr0_q <= kr0_d;
      kr1_q <= kr1_d;
      kr2_q <= kr2_d;
      kr3_q <= kr3_d;
    end
  end

  assign subkey = kr0_q;

endmodule

// File: rtl/simon_enc_ctrl.sv
// Iterative Simon 32/64 encryption controller: accepts a pt/key pair, runs the
// round cell ROUNDS times with on-the-fly subkeys, then holds ct until taken.
module simon_enc_ctrl
  import simon_pkg::*;
#(
  parameter int ROUNDS = 32,
  parameter int CNT_W  = 5
) (
  input  logic clk,
  input  logic rst,
  simon_enc_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           pt_q, pt_d;
  logic [31:0]           ct_q, ct_d;
  logic                  accept, step;
  logic [SIMON_WORD-1:0] u_in, l_in, u_cphrtxt, l_cphrtxt, subkey;

  assign accept = (state_q == IDLE) && bus.in_valid;
  assign step   = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pt_d    = pt_q;
    ct_d    = ct_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          pt_d    = bus.pt;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // The counter parks on the last round rather than wrapping.
        if (cnt_q == LAST) begin
          state_d = CAPT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CAPT: begin
        ct_d    = {u_cphrtxt, l_cphrtxt};
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pt_q    <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pt_q    <= pt_d;
      ct_q    <= ct_d;
    end
  end

  // Round 0 starts from the latched plaintext; later rounds feed back.
  always_comb begin
    u_in = u_cphrtxt;
    l_in = l_cphrtxt;
    if (cnt_q == '0) begin
      u_in = pt_q[31:16];
      l_in = pt_q[15:0];
    end
  end

  simon_key_sched #(
    .CNT_W (CNT_W)
  ) u_key_sched (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .step   (step),
    .key    (bus.key),
    .idx    (cnt_q),
    .subkey (subkey)
  );

  round u_round (
    .clk       (clk),
    .rst       (rst),
    .u_in      (u_in),
    .l_in      (l_in),
    .subkey    (subkey),
    .u_cphrtxt (u_cphrtxt),
    .l_cphrtxt (l_cphrtxt)
  );

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.ct        = ct_q;

endmodule

// File: tb/tb_simon_enc_ctrl.sv
// Self-checking bench for simon_enc_ctrl: transaction-level Simon model plus
// per-cycle comparison of the handshake outputs, ct and the live subkey.
module tb_simon_enc_ctrl;

  localparam int ROUNDS = 32;
  localparam int CNT_W  = 5;
  localparam logic [31:0] KAT_PT  = 32'h6565_6877;
  localparam logic [63:0] KAT_KEY = 64'h1918_1110_0908_0100;
  localparam logic [31:0] KAT_CT  = 32'hC69B_E9BB;

  string z0_str = "11111010001001010110000111001101111101000100101011000011100110";

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic started = 1'b0;

  int          m_timer = 0;
  logic        m_ovalid = 1'b0;
  logic [31:0] m_ct = '0;
  logic [31:0] m_pend = '0;
  logic [63:0] m_key = '0;

  simon_enc_ctrl_if bus_if ();

  simon_enc_ctrl #(
    .ROUNDS (ROUNDS),
    .CNT_W  (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rotr(input logic [15:0] v, input int n);
    return (v >> n) | (v << (16 - n));
  endfunction

  function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
    return rotr(v, 16 - n);
  endfunction

  function automatic logic z_at(input int j);
    return z0_str[j] == "1";
  endfunction

  // Subkey k_idx of the Simon 32/64 schedule, expanded from scratch.
  function automatic logic [15:0] key_at(input logic [63:0] k, input int idx);
    logic [15:0] w [0:63];
    logic [15:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[16*i +: 16];
    for (int i = 4; i <= idx; i++) begin
      t    = rotr(w[i-1], 3) ^ w[i-3];
      t    = t ^ rotr(t, 1);
      w[i] = 16'hFFFC ^ w[i-4] ^ t ^ {15'b0, z_at(i - 4)};
    end
    return w[idx];
  endfunction

  function automatic logic [31:0] simon_ref(input logic [31:0] p, input logic [63:0] k);
    logic [15:0] x, y, t;
    x = p[31:16];
    y = p[15:0];
    for (int r = 0; r < ROUNDS; r++) begin
      t = x;
      x = y ^ ((rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2)) ^ key_at(k, r);
      y = t;
    end
    return {x, y};
  endfunction

  function automatic logic m_idle();
    return !m_ovalid && (m_timer == 0);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Transaction model: an accepted block becomes visible ROUNDS+1 edges later.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      started  = 1'b1;
      m_timer  = 0;
      m_ovalid = 1'b0;
      m_ct     = '0;
    end else if (started) begin
      if (m_ovalid) begin
        if (bus_if.out_ready) m_ovalid = 1'b0;
      end else if (m_timer > 0) begin
        m_timer--;
        if (m_timer == 0) begin
          m_ovalid = 1'b1;
          m_ct     = m_pend;
        end
      end else if (bus_if.in_valid) begin
        m_pend  = simon_ref(bus_if.pt, bus_if.key);
        m_key   = bus_if.key;
        m_timer = ROUNDS + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checkOutput("in_ready", 64'(bus_if.in_ready), 64'(!rst && m_idle()));
      checkOutput("busy", 64'(bus_if.busy), 64'(!m_idle()));
      checkOutput("out_valid", 64'(bus_if.out_valid), 64'(m_ovalid));
      checkOutput("ct", 64'(bus_if.ct), 64'(m_ct));
      if (!m_ovalid && m_timer >= 2 && m_timer <= ROUNDS + 1)
        checkOutput("subkey", 64'(dut.subkey), 64'(key_at(m_key, ROUNDS + 1 - m_timer)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic [31:0] p, input logic [63:0] k,
                               input logic ordy);
    bus_if.in_valid  = iv;
    bus_if.pt        = p;
    bus_if.key       = k;
    bus_if.out_ready = ordy;
    tick();
  endtask

  task automatic wait_valid(output int at);
    int n = 0;
    while (bus_if.out_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (bus_if.out_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout_out_valid actual=0 expected=1");
    end
    at = cyc;
  endtask

  task automatic drain();
    int n = 0;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    while (bus_if.in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (bus_if.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout_idle actual=0 expected=1");
    end
    bus_if.out_ready = 1'b0;
  endtask

  initial begin
    int t0, t1, t2;
    bus_if.in_valid  = 1'b0;
    bus_if.pt        = '0;
    bus_if.key       = '0;
    bus_if.out_ready = 1'b0;

    checkOutput("model_kat_ct", 64'(simon_ref(KAT_PT, KAT_KEY)), 64'(KAT_CT));
    checkOutput("model_k4", 64'(key_at(KAT_KEY, 4)), 64'h71C3);

    rst = 1'b1;
    repeat (3) applyStimulus(1'b0, '0, '0, 1'b0);
    checkOutput("rst_in_ready", 64'(bus_if.in_ready), 64'd0);
    rst = 1'b0;
    tick();
    checkOutput("post_rst_in_ready", 64'(bus_if.in_ready), 64'd1);

    // KAT with a stray request mid-run and back-pressure on the result
    applyStimulus(1'b1, KAT_PT, KAT_KEY, 1'b0);
    t0 = cyc;
    repeat (5) applyStimulus(1'b0, '0, '0, 1'b0);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 64'h0123_4567_89AB_CDEF, 1'b0);
    bus_if.in_valid = 1'b0;
    wait_valid(t1);
    checkOutput("kat_latency", 64'(t1 - t0), 64'(ROUNDS + 1));
    checkOutput("kat_ct", 64'(bus_if.ct), 64'(KAT_CT));
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b0);
      checkOutput("bp_valid", 64'(bus_if.out_valid), 64'd1);
      checkOutput("bp_ct", 64'(bus_if.ct), 64'(KAT_CT));
      checkOutput("bp_in_ready", 64'(bus_if.in_ready), 64'd0);
    end
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("release_in_ready", 64'(bus_if.in_ready), 64'd1);
    checkOutput("release_valid", 64'(bus_if.out_valid), 64'd0);
    bus_if.out_ready = 1'b0;

    // Abort at cnt=10, then a clean KAT
    applyStimulus(1'b1, KAT_PT, KAT_KEY, 1'b0);
    repeat (10) applyStimulus(1'b0, '0, '0, 1'b0);
    rst = 1'b1;
    tick();
    checkOutput("abort_valid", 64'(bus_if.out_valid), 64'd0);
    checkOutput("abort_busy", 64'(bus_if.busy), 64'd0);
    checkOutput("abort_ct", 64'(bus_if.ct), 64'd0);
    checkOutput("abort_in_ready", 64'(bus_if.in_ready), 64'd0);
    rst = 1'b0;
    applyStimulus(1'b1, KAT_PT, KAT_KEY, 1'b0);
    t0 = cyc;
    bus_if.in_valid = 1'b0;
    wait_valid(t1);
    checkOutput("rerun_latency", 64'(t1 - t0), 64'(ROUNDS + 1));
    checkOutput("rerun_ct", 64'(bus_if.ct), 64'(KAT_CT));
    drain();

    // Back-to-back with in_valid and out_ready both held high
    applyStimulus(1'b1, KAT_PT, KAT_KEY, 1'b1);
    wait_valid(t1);
    checkOutput("b2b_ct0", 64'(bus_if.ct), 64'(KAT_CT));
    tick();
    wait_valid(t2);
    checkOutput("b2b_ct1", 64'(bus_if.ct), 64'(KAT_CT));
    checkOutput("b2b_spacing", 64'(t2 - t1), 64'(ROUNDS + 3));
    drain();

    // Random traffic including occasional resets
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      applyStimulus(($urandom_range(0, 3) == 0), $urandom, {$urandom, $urandom},
                    ($urandom_range(0, 2) != 0));
    end
    rst = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
